// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: enables the ring, synchronizes its output and counts rising
// edges over a programmable clk window. Define RING_GATE_EN to stop the ring outside WARMUP/MEASURE.
module ring_osc_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int WARM_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] win_cycles,
  input  logic             osc_in,
  output logic             ring_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int WARM_W = $clog2(WARM_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_MEASURE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, done_q;
  logic [2:0]        sync_q;   // [0]=s1, [1]=s2, [2]=s3 (edge history)
  logic              osc_rise;

  assign osc_rise = sync_q[1] & ~sync_q[2];

  // NOTE: every variable gets a default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    win_cnt_d = win_cnt_q;
    warm_d    = warm_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          win_d   = win_cycles;
          count_d = '0;
          ovf_d   = 1'b0;
          warm_d  = WARM_W'(WARM_CYCLES - 1);
          state_d = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (warm_q == '0) begin
          if (win_q == '0) begin
            state_d = S_DONE;
          end else begin
            win_cnt_d = win_q;
            state_d   = S_MEASURE;
          end
        end else begin
          warm_d = warm_q - 1'b1;
        end
      end
      S_MEASURE: begin
        if (osc_rise) begin
          if (&count_q) ovf_d = 1'b1;
          else          count_d = count_q + 1'b1;
        end
        win_cnt_d = win_cnt_q - 1'b1;
        // The cycle the counter reads 1 is the last one sampled.
        if (win_cnt_q == WIN_W'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      win_cnt_q <= '0;
      warm_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      win_cnt_q <= win_cnt_d;
      warm_q    <= warm_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      busy_q    <= (state_d == S_WARMUP) || (state_d == S_MEASURE);
      done_q    <= (state_d == S_DONE);
      sync_q    <= {sync_q[1:0], osc_in};
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = ovf_q;

`ifdef RING_GATE_EN
  // The ring runs exactly while a measurement is in WARMUP or MEASURE, i.e. while busy.
  assign ring_en = busy_q;
`else
  assign ring_en = 1'b1;
`endif

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Directed, scoreboard-based bench for ring_osc_freq_meter (default 16-bit and a 4-bit saturating
// instance). Cycle numbering: the cycle in which start is accepted is cycle 1.
module tb_ring_osc_freq_meter;

  localparam int WARM = 8;
`ifdef RING_GATE_EN
  localparam logic IDLE_RING = 1'b0;
`else
  localparam logic IDLE_RING = 1'b1;
`endif

  typedef struct {
    int   lat;
    int   lo;
    int   hi;
    logic ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        start;
  logic        sel;
  logic [15:0] win;
  logic        osc_a, osc_b;

  logic        start_a, start_b;
  logic        ring_a, busy_a, done_a, ovf_a;
  logic        ring_b, busy_b, done_b, ovf_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;

  logic        obs_ring, obs_busy, obs_done, obs_ovf;
  logic [31:0] obs_count;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  assign start_a   = start & ~sel;
  assign start_b   = start & sel;
  assign obs_ring  = sel ? ring_b : ring_a;
  assign obs_busy  = sel ? busy_b : busy_a;
  assign obs_done  = sel ? done_b : done_a;
  assign obs_ovf   = sel ? ovf_b  : ovf_a;
  assign obs_count = sel ? 32'(count_b) : 32'(count_a);

  ring_osc_freq_meter #(.CNT_W(16), .WIN_W(16), .WARM_CYCLES(WARM)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .win_cycles(win), .osc_in(osc_a),
    .ring_en(ring_a), .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a)
  );

  ring_osc_freq_meter #(.CNT_W(4), .WIN_W(16), .WARM_CYCLES(WARM)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .win_cycles(win), .osc_in(osc_b),
    .ring_en(ring_b), .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  // Ring outputs: 8-clk and 4-clk periods, phased so they never coincide with a clk edge.
  initial begin
    osc_a = 1'b0;
    #3;
    forever #40 osc_a = ~osc_a;
  end
  initial begin
    osc_b = 1'b0;
    #7;
    forever #20 osc_b = ~osc_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
    checks++;
    assert (!$isunknown(obs) && int'(obs) >= lo && int'(obs) <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Called at a negedge: drives start in that cycle, follows the run to done and checks it.
  // poke_cyc re-pulses start (with a new win_cycles) in that cycle; poke_done pulses it in DONE.
  task automatic measure(input logic s, input int w, input int lo, input int hi, input logic ovf,
                         input int poke_cyc, input logic poke_done);
    exp_t e;
    int   cyc;
    logic busy_bad, ring_bad;
    sel   = s;
    start = 1'b1;
    win   = 16'(w);
    e.lat = 1 + WARM + w + 1;
    e.lo  = lo;
    e.hi  = hi;
    e.ovf = ovf;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    win      = 16'(w ^ 'h2a);
    cyc      = 2;
    busy_bad = 1'b0;
    ring_bad = 1'b0;
    check($sformatf("accept_clears_count_w%0d", w), obs_count, 0);
    check($sformatf("accept_clears_ovf_w%0d", w), 32'(obs_ovf), 0);
    while (obs_done !== 1'b1 && cyc <= e.lat + 20) begin
      if (obs_busy !== 1'b1) busy_bad = 1'b1;
      if (obs_ring !== 1'b1) ring_bad = 1'b1;
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) win = 16'(w + 7);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check($sformatf("done_seen_w%0d", w), 32'(obs_done), 1);
    check($sformatf("latency_w%0d", w), cyc, e.lat);
    check_range($sformatf("count_w%0d", w), obs_count, e.lo, e.hi);
    check($sformatf("overflow_w%0d", w), 32'(obs_ovf), 32'(e.ovf));
    check($sformatf("busy_in_done_w%0d", w), 32'(obs_busy), 0);
    check($sformatf("busy_held_w%0d", w), 32'(busy_bad), 0);
    check($sformatf("ring_en_active_w%0d", w), 32'(ring_bad), 0);
    check($sformatf("ring_en_done_w%0d", w), 32'(obs_ring), 32'(IDLE_RING));
    start = poke_done;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("post_done_busy_w%0d", w), 32'(obs_busy), 0);
    check($sformatf("post_done_pulse_w%0d", w), 32'(obs_done), 0);
  endtask

  initial begin
    int pulses;
    rst_a = 1'b1;
    rst_b = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    win   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_count", 32'(count_a), 0);
    check("rst_ovf", 32'(ovf_a), 0);
    check("rst_ring_en", 32'(ring_a), 32'(IDLE_RING));
    check("rst_ring_en_b", 32'(ring_b), 32'(IDLE_RING));
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ring_en", 32'(ring_a), 32'(IDLE_RING));

    // Basic count: 8-clk period over 64 cycles -> 8 +/- 1 edges.
    measure(1'b0, 64, 7, 9, 1'b0, 0, 1'b0);
    // Zero window: no edges counted although the ring toggles.
    measure(1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
    // Saturation on the 4-bit instance, then the next accept clears count and overflow.
    measure(1'b1, 200, 15, 15, 1'b1, 0, 1'b0);
    measure(1'b1, 0, 0, 0, 1'b0, 0, 1'b0);
    // Busy protection: start mid-MEASURE and in DONE ignored; start right after DONE accepted.
    measure(1'b0, 16, 1, 3, 1'b0, 15, 1'b1);
    measure(1'b0, 16, 1, 3, 1'b0, 0, 1'b0);

    // Reset in the middle of MEASURE.
    sel   = 1'b0;
    start = 1'b1;
    win   = 16'd64;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    check("pre_reset_counting", 32'(count_a != 0), 1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("mid_rst_busy", 32'(busy_a), 0);
    check("mid_rst_count", 32'(count_a), 0);
    check("mid_rst_ovf", 32'(ovf_a), 0);
    check("mid_rst_done", 32'(done_a), 0);
    check("mid_rst_ring_en", 32'(ring_a), 32'(IDLE_RING));
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      if (done_a === 1'b1 || busy_a !== 1'b0) pulses++;
    end
    check("no_activity_after_reset", pulses, 0);
    measure(1'b0, 64, 7, 9, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_osc_freq_meter.md
Name: ring_osc_freq_meter

Overview:
- Sits directly downstream of the ring oscillator and provides its enable.
- Counts rising edges of the free-running ring output over a programmable window of system-clock cycles.
- Presents the count as a frequency/delay measurement to the chip I/O.
- The ring output is asynchronous to clk; it is synchronized internally before counting.

Parameters:
- CNT_W, 16, width of edge counter and count output.
- WIN_W, 16, width of window length input and window counter.
- WARM_CYCLES, 8, clk cycles the ring runs before counting starts, so the ring settles after enable (must be >= 3).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a measurement; sampled only in IDLE.
- win_cycles  input  WIN_W  window length in clk cycles; latched on start accept.
- osc_in  input  1  ring oscillator output, asynchronous; frequency must be <= clk/4.
- ring_en  output  1  drives the ring's nrst input; 1 means the ring runs.
- busy  output  1  high from start accept until done.
- done  output  1  one-cycle pulse when count is valid.
- count  output  CNT_W  edges counted in the last window; held until the next start accept.
- overflow  output  1  count saturated during the last window.

Behaviour:
- Reset values (synchronous): state=IDLE, count=0, overflow=0, done=0, busy=0, sync flops=0, window counter=0. ring_en=1 without RING_GATE_EN, 0 with it.
- Synchronizer:
  - osc_in passes through 2 flops (s1, s2), then an edge flop s3.
  - edge = s2 & ~s3.
  - Edges appear 2-3 clk cycles after the pin, so boundary edges may shift into or out of the window. Accuracy is +/-1 count.
- IDLE:
  - busy=0.
  - If start=1: latch win_cycles into win_q, clear count and overflow, load warm counter with WARM_CYCLES-1, set busy=1, go to WARMUP on the next cycle.
- WARMUP:
  - Edges ignored.
  - Warm counter decrements each cycle. At 0: load window counter with win_q and go to MEASURE. If win_q=0, go straight to DONE instead.
- MEASURE:
  - Each cycle with edge=1: count+1.
  - If count is all-ones, count holds and overflow sets to 1; overflow is sticky for the window.
  - Window counter decrements each cycle. The cycle it reads 1 is the last counted cycle; then go to DONE.
  - Exactly win_q cycles are counted.
- DONE:
  - done=1 for this single cycle, busy=0, return to IDLE.
- Latency: done is asserted exactly 1 + WARM_CYCLES + win_q + 1 cycles after the start-accept edge (win_q=0: 1 + WARM_CYCLES + 1).
- start while busy is ignored; it is not queued.
- start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted.
- win_cycles changes after accept have no effect.
- count is not updated outside MEASURE. Edges during IDLE, WARMUP and DONE are discarded.
- reset mid-operation: next cycle is IDLE with all reset values. No done pulse, count=0.

Optional Feature:
- Macro: RING_GATE_EN.
- Defined: ring_en=1 only in WARMUP and MEASURE, 0 otherwise, including reset. The ring is stopped when idle to save power.
- Undefined: ring_en is constant 1 after reset and the ring runs continuously. WARMUP still occurs so timing is identical in both builds.

Test Plan:
- Basic count: osc_in period 8 clk cycles (50% duty), win_cycles=64, WARM_CYCLES=8, start pulse -> done exactly 74 cycles after accept, count in {7,8,9}, overflow=0, busy high throughout.
- Saturation: CNT_W=4, osc period 4 clk cycles, win_cycles=200 -> count=15, overflow=1 at done; next start clears both to 0 on accept.
- Zero window: win_cycles=0 -> done 10 cycles after accept, count=0, overflow=0, no edges counted despite a toggling osc_in.
- Busy protection: start re-pulsed mid-MEASURE and in the DONE cycle -> single done pulse, win_cycles change after accept has no effect on timing; start one cycle after done -> a new measurement begins.
- Reset mid-measure: reset=1 for 1 cycle during MEASURE -> next cycle busy=0, count=0, overflow=0, done never pulses; a fresh start then measures normally.
- RING_GATE_EN build: ring_en=0 in reset and IDLE, 1 from the first WARMUP cycle through the last MEASURE cycle, 0 in DONE. Without the macro, ring_en=1 at all times after reset.
